// File: rtl/spi_master_ctrl.sv
// Transaction sequencer and round-robin arbiter for two clients of spi_master.
// Drives start/load/read through load, 8-bit shift and read-back, one CS per client.
module spi_master_ctrl #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [7:0] req0_data_i,
  input  logic [7:0] req1_data_i,
  output logic [1:0] gnt_o,
  output logic [1:0] rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       busy_o,
  output logic [1:0] cs_n_o,
  output logic       spi_start_o,
  output logic       spi_load_o,
  output logic       spi_read_o,
  output logic [7:0] spi_data_o,
  input  logic [7:0] spi_data_i
);

  // Wide enough for GAP_CYCLES, and at least one bit when GAP_CYCLES is 0.
  localparam int unsigned GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_CAPTURE,
    S_DONE,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q;
  logic [GW-1:0]   gap_cnt_q;
  logic            last_q;
  logic            sel_q;
  logic            gnt_idx;

  assign busy_o = (state_q != S_IDLE);

  // Round-robin: with both requesting, the client that was not granted last wins.
  always_comb begin
    gnt_o   = '0;
    gnt_idx = 1'b0;
    if (state_q == S_IDLE && gap_cnt_q == '0) begin
      case (req_i)
        2'b01:   begin gnt_o = 2'b01; gnt_idx = 1'b0; end
        2'b10:   begin gnt_o = 2'b10; gnt_idx = 1'b1; end
        2'b11:   begin
          gnt_idx = ~last_q;
          gnt_o   = last_q ? 2'b01 : 2'b10;
        end
        default: begin gnt_o = '0; gnt_idx = 1'b0; end
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    spi_start_o = 1'b0;
    spi_load_o  = 1'b0;
    spi_read_o  = 1'b0;
    cs_n_o      = '1;
    rsp_valid_o = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_o != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        spi_start_o    = 1'b1;
        spi_load_o     = 1'b1;
        cs_n_o[sel_q]  = 1'b0;
        state_d        = S_SHIFT;
      end
      S_SHIFT: begin
        spi_start_o    = 1'b1;
        cs_n_o[sel_q]  = 1'b0;
        if (bit_cnt_q == 3'd7) state_d = S_LATCH;
      end
      S_LATCH: begin
        spi_start_o    = 1'b1;
        spi_read_o     = 1'b1;
        cs_n_o[sel_q]  = 1'b0;
        state_d        = S_CAPTURE;
      end
      S_CAPTURE: begin
        spi_read_o     = 1'b1;
        cs_n_o[sel_q]  = 1'b0;
        state_d        = S_DONE;
      end
      S_DONE: begin
        rsp_valid_o[sel_q] = 1'b1;
        state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      spi_data_o <= '0;
      rsp_data_o <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= (state_q == S_SHIFT) ? bit_cnt_q + 3'd1 : 3'd0;
      if (gnt_o != '0) begin
        last_q     <= gnt_idx;
        sel_q      <= gnt_idx;
        spi_data_o <= gnt_idx ? req1_data_i : req0_data_i;
      end
      if (state_q == S_CAPTURE) rsp_data_o <= spi_data_i;
      // Counter is loaded in DONE and reaches 0 on the last GAP cycle.
      if (state_q == S_DONE)       gap_cnt_q <= GW'(GAP_CYCLES);
      else if (gap_cnt_q != '0)    gap_cnt_q <= gap_cnt_q - GW'(1);
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural spi_master and slave.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] req;
  logic [7:0] d0, d1;
  logic [1:0] gnt, rsp_valid, cs_n;
  logic [7:0] rsp_data, spi_data, spi_din;
  logic       busy, spi_start, spi_load, spi_read;

  logic [1:0] req_z;
  logic [1:0] gnt_z, rsp_valid_z, cs_n_z;
  logic [7:0] rsp_data_z, spi_data_z;
  logic [7:0] spi_din_z = 8'h00;
  logic       busy_z, start_z, load_z, read_z;

  spi_master_ctrl #(.GAP_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req0_data_i(d0), .req1_data_i(d1),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .busy_o(busy),
    .cs_n_o(cs_n), .spi_start_o(spi_start), .spi_load_o(spi_load),
    .spi_read_o(spi_read), .spi_data_o(spi_data), .spi_data_i(spi_din)
  );

  spi_master_ctrl #(.GAP_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req_z), .req0_data_i(8'h00), .req1_data_i(8'h5C),
    .gnt_o(gnt_z), .rsp_valid_o(rsp_valid_z), .rsp_data_o(rsp_data_z), .busy_o(busy_z),
    .cs_n_o(cs_n_z), .spi_start_o(start_z), .spi_load_o(load_z),
    .spi_read_o(read_z), .spi_data_o(spi_data_z), .spi_data_i(spi_din_z)
  );

  // Master and slave models: LSB-first out, MISO enters at bit 7.
  logic [7:0] m_sh, m_dout, s_sh, slave_byte;
  logic       mosi;
  assign mosi    = m_sh[0];
  assign spi_din = m_dout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sh <= 8'h00; m_dout <= 8'h00; s_sh <= 8'h00;
    end else if (spi_start && spi_load) begin
      m_sh <= spi_data; s_sh <= slave_byte;
    end else if (spi_start && spi_read) begin
      m_dout <= m_sh;
    end else if (spi_start) begin
      m_sh <= {s_sh[0], m_sh[7:1]};
      s_sh <= {1'b0, s_sh[7:1]};
    end
  end

  int cyc_n = 0;
  int cs_both = 0;
  int gnt_busy = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) begin
    if (cs_n === 2'b00) cs_both = cs_both + 1;
    if (busy === 1'b1 && gnt !== 2'b00) gnt_busy = gnt_busy + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_gnt(input logic [1:0] exp, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      smp();
      if (gnt !== 2'b00) begin at = cyc_n; break; end
      tick();
    end
    chk("grant", gnt, exp);
  endtask

  task automatic wait_rsp(input logic [1:0] exp, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      smp();
      if (rsp_valid !== 2'b00) begin at = cyc_n; break; end
      tick();
    end
    chk("rsp_valid", rsp_valid, exp);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      smp();
      if (busy === 1'b0) break;
      tick();
    end
    chk("idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g0, g1, g2, r, r2, n, csh, cs0low, pulses;
    int gz[4];
    logic [7:0] a5;

    rst = 1'b1; req = 2'b00; d0 = 8'h00; d1 = 8'h00; slave_byte = 8'h00; req_z = 2'b00;
    #2;
    chk("rst_cs_n", cs_n, 2'b11);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_spi_data", spi_data, 8'h00);
    chk("rst_ctrl", {spi_start, spi_load, spi_read}, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cs_n_z", cs_n_z, 2'b11);
    tick(); tick();
    rst = 1'b0;

    // Lone client 0: tx 0xA5, slave returns 0x3C.
    tick();
    req = 2'b01; d0 = 8'hA5; slave_byte = 8'h3C;
    wait_gnt(2'b01, 5, g);
    tick(); req = 2'b00; smp();
    chk("load_ctrl", {spi_start, spi_load, spi_read}, 3'b110);
    chk("load_cs_n", cs_n, 2'b10);
    chk("load_busy", busy, 1'b1);
    chk("load_spi_data", spi_data, 8'hA5);
    a5 = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      tick(); smp();
      chk("mosi", mosi, a5[k]);
      chk("shift_cs_n", cs_n, 2'b10);
      chk("shift_ctrl", {spi_start, spi_load, spi_read}, 3'b100);
    end
    tick(); smp();
    chk("latch_ctrl", {spi_start, spi_load, spi_read}, 3'b101);
    chk("latch_cs_n", cs_n, 2'b10);
    tick(); smp();
    chk("capture_ctrl", {spi_start, spi_load, spi_read}, 3'b001);
    chk("capture_cs_n", cs_n, 2'b10);
    chk("capture_rsp_valid", rsp_valid, 2'b00);
    tick(); smp();
    chk("done_rsp_valid", rsp_valid, 2'b01);
    chk("done_rsp_data", rsp_data, 8'h3C);
    chk("done_cs_n", cs_n, 2'b11);
    chk("done_latency", cyc_n - g, 12);
    tick(); smp();
    chk("gap_busy", busy, 1'b1);
    chk("gap_rsp_valid", rsp_valid, 2'b00);

    // Both request right after reset: client 0 first, client 1 at +15.
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    tick();
    req = 2'b11; d0 = 8'h11; d1 = 8'h22; slave_byte = 8'h96;
    wait_gnt(2'b01, 3, g0);
    tick(); req = 2'b10; smp();
    chk("both_spi_data0", spi_data, 8'h11);
    wait_gnt(2'b10, 30, g1);
    chk("both_spacing", g1 - g0, 15);
    tick(); req = 2'b00; smp();
    chk("both_spi_data1", spi_data, 8'h22);
    wait_rsp(2'b10, 20, r);
    chk("both_rsp_data", rsp_data, 8'h96);
    chk("both_latency", r - g1, 12);

    // GAP_CYCLES=0 instance, client 1 holding its request.
    tick();
    req_z = 2'b10; n = 0; csh = 0; cs0low = 0;
    for (int i = 0; i < 30; i++) begin
      smp();
      if (gnt_z !== 2'b00) begin
        if (n < 4) gz[n] = cyc_n;
        n++;
      end
      if (busy_z === 1'b1 && cs_n_z[1] === 1'b1) csh++;
      if (cs_n_z[0] !== 1'b1) cs0low++;
      tick();
    end
    req_z = 2'b00;
    chk("g0_grant_count", n, 3);
    chk("g0_spacing_a", gz[1] - gz[0], 13);
    chk("g0_spacing_b", gz[2] - gz[1], 13);
    chk("g0_cs_high_busy", csh, 2);
    chk("g0_cs0_low", cs0low, 0);

    // Client 0 requests during a client 1 shift; data changed before grant.
    wait_idle(30);
    tick();
    req = 2'b10; d1 = 8'hC3; slave_byte = 8'h81;
    wait_gnt(2'b10, 3, g);
    tick(); req = 2'b00; smp();
    chk("c1_spi_data", spi_data, 8'hC3);
    tick(); tick();
    req = 2'b01; d0 = 8'h5A;
    wait_rsp(2'b10, 15, r);
    chk("c1_rsp_data", rsp_data, 8'h81);
    chk("c1_latency", r - g, 12);
    tick(); d0 = 8'h77; slave_byte = 8'h18;
    wait_gnt(2'b01, 10, g2);
    chk("c0_after_gap", g2 - r, 3);
    tick(); req = 2'b00; d0 = 8'h00; smp();
    chk("c0_spi_data", spi_data, 8'h77);
    wait_rsp(2'b01, 15, r2);
    chk("c0_rsp_data", rsp_data, 8'h18);

    // Reset in the fifth SHIFT cycle.
    wait_idle(30);
    tick();
    req = 2'b01; d0 = 8'hE7; slave_byte = 8'h42;
    wait_gnt(2'b01, 5, g);
    tick(); req = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_cs_n", cs_n, 2'b11);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ctrl", {spi_start, spi_load, spi_read}, 3'b000);
    tick(); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      smp();
      if (rsp_valid !== 2'b00) pulses++;
      tick();
    end
    chk("abort_no_rsp", pulses, 0);
    req = 2'b11; d1 = 8'h99;
    wait_gnt(2'b01, 3, g);
    tick(); req = 2'b00;
    wait_rsp(2'b01, 20, r);
    chk("abort_recover_data", rsp_data, 8'h42);

    // MISO held high.
    wait_idle(30);
    tick();
    req = 2'b10; d1 = 8'h0F; slave_byte = 8'hFF;
    wait_gnt(2'b10, 5, g);
    tick(); req = 2'b00;
    wait_rsp(2'b10, 20, r);
    chk("miso1_rsp_data", rsp_data, 8'hFF);
    tick(); req = 2'b10;
    wait_gnt(2'b10, 10, g2);
    chk("miso1_next_grant", g2 - r, 3);
    tick(); req = 2'b00;
    wait_idle(30);

    chk("cs_never_both", cs_both, 0);
    chk("no_grant_busy", gnt_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
